// File: rtl/orientation_pkg.sv
// Shared types and code table for the roll/pitch orientation tracker.
// The direction encoding puts the sign in bit 1 so that DIR_NEG reads as -1.
package orientation_pkg;

    typedef enum logic [1:0] {
        DIR_NEUTRAL = 2'b00,
        DIR_POS     = 2'b01,
        DIR_NEG     = 2'b11
    } dir_t;

    typedef logic [3:0] orient_t;

    localparam orient_t ORIENT_NEUTRAL    = 4'd0;
    localparam orient_t ORIENT_UP         = 4'd1;
    localparam orient_t ORIENT_UP_RIGHT   = 4'd2;
    localparam orient_t ORIENT_RIGHT      = 4'd3;
    localparam orient_t ORIENT_DOWN_RIGHT = 4'd4;
    localparam orient_t ORIENT_DOWN       = 4'd5;
    localparam orient_t ORIENT_DOWN_LEFT  = 4'd6;
    localparam orient_t ORIENT_LEFT       = 4'd7;
    localparam orient_t ORIENT_UP_LEFT    = 4'd8;

    // Roll positive is right, pitch positive is up; the unused 2'b10 maps to neutral.
    function automatic orient_t encode_orientation(dir_t roll_dir, dir_t pitch_dir);
        orient_t code;
        case ({roll_dir, pitch_dir})
            {DIR_NEUTRAL, DIR_NEUTRAL}: code = ORIENT_NEUTRAL;
            {DIR_NEUTRAL, DIR_POS}:     code = ORIENT_UP;
            {DIR_POS,     DIR_POS}:     code = ORIENT_UP_RIGHT;
            {DIR_POS,     DIR_NEUTRAL}: code = ORIENT_RIGHT;
            {DIR_POS,     DIR_NEG}:     code = ORIENT_DOWN_RIGHT;
            {DIR_NEUTRAL, DIR_NEG}:     code = ORIENT_DOWN;
            {DIR_NEG,     DIR_NEG}:     code = ORIENT_DOWN_LEFT;
            {DIR_NEG,     DIR_NEUTRAL}: code = ORIENT_LEFT;
            {DIR_NEG,     DIR_POS}:     code = ORIENT_UP_LEFT;
            default:                    code = ORIENT_NEUTRAL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/orientation_tracker_axis.sv
// Per-axis three-state hysteresis classifier (NEUTRAL / POS / NEG).
// Compares at DATA_W+1 bits so negating ENTER_TH and the most negative sample are safe.
module axis_hysteresis
    import orientation_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ENTER_TH = 400,
    parameter int EXIT_TH  = 300
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] raw,
    output dir_t                     dir
);

    localparam logic signed [DATA_W:0] ENTER_POS = (DATA_W+1)'(ENTER_TH);
    localparam logic signed [DATA_W:0] ENTER_NEG = -ENTER_POS;
    localparam logic signed [DATA_W:0] EXIT_POS  = (DATA_W+1)'(EXIT_TH);
    localparam logic signed [DATA_W:0] EXIT_NEG  = -EXIT_POS;

    logic signed [DATA_W:0] raw_ext;
    logic                   above_enter;
    logic                   below_neg_enter;
    logic                   below_exit;
    logic                   above_neg_exit;
    dir_t                   dir_reg;

    assign raw_ext = {raw[DATA_W-1], raw};

    // Strict comparisons: a sample sitting exactly on a threshold does not cross it.
    assign above_enter     = raw_ext > ENTER_POS;
    assign below_neg_enter = raw_ext < ENTER_NEG;
    assign below_exit      = raw_ext < EXIT_POS;
    assign above_neg_exit  = raw_ext > EXIT_NEG;

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_reg <= DIR_NEUTRAL;
        end else if (sample_valid) begin
            case (dir_reg)
                DIR_NEUTRAL: begin
                    if (above_enter)
                        dir_reg <= DIR_POS;
                    else if (below_neg_enter)
                        dir_reg <= DIR_NEG;
                end
                DIR_POS: begin
                    if (below_neg_enter)
                        dir_reg <= DIR_NEG;
                    else if (below_exit)
                        dir_reg <= DIR_NEUTRAL;
                end
                DIR_NEG: begin
                    if (above_enter)
                        dir_reg <= DIR_POS;
                    else if (above_neg_exit)
                        dir_reg <= DIR_NEUTRAL;
                end
                default: dir_reg <= DIR_NEUTRAL;
            endcase
        end
    end

    assign dir = dir_reg;

endmodule

// File: rtl/orientation_tracker.sv
// Registered roll/pitch orientation tracker: per-axis hysteresis followed by a
// debounce stage that commits a code only after STABLE_SAMPLES matching samples.
module orientation_tracker
    import orientation_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ENTER_TH       = 400,
    parameter int EXIT_TH        = 300,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] roll_raw,
    input  logic signed [DATA_W-1:0] pitch_raw,
    output logic [3:0]               orientation,
    output logic                     orient_valid,
    output logic                     orient_changed
);

    localparam int              CW       = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0]   STABLE_C = CW'(STABLE_SAMPLES);

    logic signed [DATA_W-1:0] raw_arr [2];
    dir_t                     dir_arr [2];

    assign raw_arr[0] = roll_raw;
    assign raw_arr[1] = pitch_raw;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            axis_hysteresis #(
                .DATA_W   (DATA_W),
                .ENTER_TH (ENTER_TH),
                .EXIT_TH  (EXIT_TH)
            ) u_axis (
                .clk          (clk),
                .rst          (rst),
                .sample_valid (sample_valid),
                .raw          (raw_arr[gi]),
                .dir          (dir_arr[gi])
            );
        end
    endgenerate

    logic          valid_d1_reg;
    orient_t       orient_reg;
    orient_t       orient_next;
    orient_t       trk_reg;
    orient_t       trk_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          valid_reg;
    logic          changed_reg;
    logic          changed_next;
    orient_t       cand;

    assign cand = encode_orientation(dir_arr[0], dir_arr[1]);

    // Debounce decision for the sample whose axis states were latched last edge.
    always_comb begin
        cnt_next     = cnt_reg;
        trk_next     = trk_reg;
        orient_next  = orient_reg;
        changed_next = 1'b0;
        if (valid_d1_reg) begin
            if (cand == orient_reg) begin
                cnt_next = '0;
            end else begin
                if (cand == trk_reg) begin
                    cnt_next = cnt_reg + CW'(1);
                end else begin
                    trk_next = cand;
                    cnt_next = CW'(1);
                end
                if (cnt_next == STABLE_C) begin
                    orient_next  = cand;
                    changed_next = 1'b1;
                    cnt_next     = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d1_reg <= 1'b0;
            orient_reg   <= ORIENT_NEUTRAL;
            trk_reg      <= ORIENT_NEUTRAL;
            cnt_reg      <= '0;
            valid_reg    <= 1'b0;
            changed_reg  <= 1'b0;
        end else begin
            valid_d1_reg <= sample_valid;
            orient_reg   <= orient_next;
            trk_reg      <= trk_next;
            cnt_reg      <= cnt_next;
            valid_reg    <= valid_d1_reg;
            changed_reg  <= changed_next;
        end
    end

    assign orientation    = orient_reg;
    assign orient_valid   = valid_reg;
    assign orient_changed = changed_reg;

endmodule

// File: tb/tb_orientation_tracker.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized samples checked every cycle against a sample-level reference model.
module tb_orientation_tracker;

    localparam int DATA_W         = 16;
    localparam int ENTER_TH       = 400;
    localparam int EXIT_TH        = 300;
    localparam int STABLE_SAMPLES = 4;

    logic                     clk;
    logic                     rst;
    logic                     sample_valid;
    logic signed [DATA_W-1:0] roll_raw;
    logic signed [DATA_W-1:0] pitch_raw;
    logic [3:0]               orientation;
    logic                     orient_valid;
    logic                     orient_changed;

    orientation_tracker #(
        .DATA_W         (DATA_W),
        .ENTER_TH       (ENTER_TH),
        .EXIT_TH        (EXIT_TH),
        .STABLE_SAMPLES (STABLE_SAMPLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .roll_raw       (roll_raw),
        .pitch_raw      (pitch_raw),
        .orientation    (orientation),
        .orient_valid   (orient_valid),
        .orient_changed (orient_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_changed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: axis state as -1/0/+1, orientation from a 3x3 table.
    int code_tbl [9] = '{6, 7, 8, 5, 0, 1, 4, 3, 2};
    int m_roll = 0, m_pitch = 0, m_orient = 0, m_trk = 0, m_cnt = 0;
    bit pend_v = 0;
    int pend_r = 0, pend_p = 0;
    int exp_orient = 0;
    bit exp_valid = 0, exp_chg = 0;

    function automatic int axis_next(input int s, input int raw);
        if (s == 0) begin
            if (raw > ENTER_TH) return 1;
            if (raw < -ENTER_TH) return -1;
            return 0;
        end
        if (s == 1) begin
            if (raw < -ENTER_TH) return -1;
            if (raw < EXIT_TH) return 0;
            return 1;
        end
        if (raw > ENTER_TH) return 1;
        if (raw > -EXIT_TH) return 0;
        return -1;
    endfunction

    task automatic model_edge();
        int cand;
        exp_chg = 0;
        if (rst) begin
            m_roll = 0; m_pitch = 0; m_orient = 0; m_trk = 0; m_cnt = 0;
            pend_v = 0; exp_valid = 0;
        end else begin
            exp_valid = pend_v;
            if (pend_v) begin
                m_roll  = axis_next(m_roll, pend_r);
                m_pitch = axis_next(m_pitch, pend_p);
                cand = code_tbl[(m_roll + 1) * 3 + (m_pitch + 1)];
                if (cand == m_orient) begin
                    m_cnt = 0;
                end else begin
                    if (cand == m_trk) m_cnt++;
                    else begin
                        m_trk = cand;
                        m_cnt = 1;
                    end
                    if (m_cnt == STABLE_SAMPLES) begin
                        m_orient = cand;
                        m_cnt = 0;
                        exp_chg = 1;
                    end
                end
            end
            pend_v = sample_valid;
            pend_r = int'(roll_raw);
            pend_p = int'(pitch_raw);
        end
        exp_orient = m_orient;
    endtask

    // Single compare process: every cycle after the active edge.
    always @(posedge clk) begin
        model_edge();
        #1;
        check("orientation", int'(orientation), exp_orient);
        check("orient_valid", int'(orient_valid), int'(exp_valid));
        check("orient_changed", int'(orient_changed), int'(exp_chg));
        if (orient_changed) begin
            check("strobe_align", int'(orient_valid), 1);
            $display("commit t=%0t orientation=%0d", $time, orientation);
        end
        if (orient_valid) n_valid++;
        if (orient_changed) n_changed++;
    end

    task automatic smp(input int r, input int p);
        sample_valid = 1'b1;
        roll_raw  = DATA_W'(r);
        pitch_raw = DATA_W'(p);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic smp_n(input int n, input int r, input int p);
        for (int i = 0; i < n; i++) smp(r, p);
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst(input int n);
        rst = 1'b1;
        sample_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clr();
        n_valid = 0;
        n_changed = 0;
    endtask

    function automatic int pick_val();
        case ($urandom_range(0, 11))
            0:  return 0;
            1:  return ENTER_TH;
            2:  return -ENTER_TH;
            3:  return EXIT_TH;
            4:  return -EXIT_TH;
            5:  return ENTER_TH + 1;
            6:  return -ENTER_TH - 1;
            7:  return EXIT_TH - 1;
            8:  return -EXIT_TH + 1;
            9:  return -32768;
            10: return 32767;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    initial begin
        int r, p, len;
        rst = 1'b1;
        sample_valid = 1'b0;
        roll_raw = '0;
        pitch_raw = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_orientation", int'(orientation), 0);
        check("reset_valid", int'(orient_valid), 0);

        // First commit and latency
        clr();
        smp_n(4, 500, 0);
        check("first_pre_latency", int'(orientation), 0);
        idle(1);
        check("first_commit", int'(orientation), 3);
        idle(1);
        check("first_valid_pulses", n_valid, 4);
        check("first_changed_pulses", n_changed, 1);

        // Hysteresis band and exact-threshold samples
        clr();
        smp_n(10, 350, 0); idle(2);
        check("hyst_hold", int'(orientation), 3);
        check("hyst_no_change", n_changed, 0);
        smp_n(4, 250, 0); idle(2);
        check("hyst_exit", int'(orientation), 0);
        smp_n(4, 400, 0); idle(2);
        check("hyst_on_threshold", int'(orientation), 0);

        // Glitch rejection
        clr();
        smp_n(3, 500, 500); smp(0, 0); smp_n(3, 500, 500); idle(2);
        check("glitch_no_commit", n_changed, 0);
        smp(500, 500); idle(2);
        check("glitch_commit", int'(orientation), 2);

        // Direct reversal and extreme value
        smp_n(4, 500, 0); idle(2);
        check("to_right", int'(orientation), 3);
        clr();
        smp_n(4, -500, 0); idle(2);
        check("reversal", int'(orientation), 7);
        check("reversal_single_change", n_changed, 1);
        smp_n(4, 0, -32768); idle(2);
        check("extreme_down", int'(orientation), 5);

        // Candidate switch
        pulse_rst(1);
        clr();
        smp_n(2, 500, 500); smp_n(4, -500, 500); idle(2);
        check("switch_commit", int'(orientation), 8);
        check("switch_single_change", n_changed, 1);

        // Idle gap holds the count
        pulse_rst(1);
        clr();
        smp_n(3, 0, 500); idle(20); smp(0, 500); idle(2);
        check("gap_commit", int'(orientation), 1);
        check("gap_changes", n_changed, 1);

        // Reset mid-run discards the count and in-flight sample
        pulse_rst(1);
        smp_n(3, 0, 500);
        pulse_rst(1);
        check("midrst_orientation", int'(orientation), 0);
        check("midrst_valid", int'(orient_valid), 0);
        clr();
        idle(2);
        check("midrst_no_strobe", n_valid, 0);
        smp(0, 500); idle(2);
        check("midrst_one_fresh", int'(orientation), 0);
        smp_n(2, 0, 500); idle(2);
        check("midrst_three_fresh", int'(orientation), 0);
        smp(0, 500); idle(2);
        check("midrst_four_fresh", int'(orientation), 1);

        // Randomized runs around the thresholds
        for (int run = 0; run < 400; run++) begin
            r = pick_val();
            p = pick_val();
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 199) == 0) pulse_rst(1);
                else if ($urandom_range(0, 3) == 0) idle(1);
                else smp(r, p);
            end
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/orientation_tracker.md
# orientation_tracker

Parametrised, registered successor to the combinational roll/pitch orientation encoder. It classifies each signed roll/pitch sample into one of nine orientation codes, 0–8, using per-axis hysteresis. A code is committed only after it has persisted for a configurable number of consecutive samples. The block sits between the IMU sample path and the display/attitude logic, and emits an update strobe and a change strobe alongside the committed code.

## Interface
Parameters:
- DATA_W, 16: width of the signed roll/pitch samples.
- ENTER_TH, 400: magnitude above which an axis leaves neutral. Constraint: EXIT_TH < ENTER_TH < 2^(DATA_W-1).
- EXIT_TH, 300: magnitude below which a tilted axis returns to neutral. Constraint: EXIT_TH >= 0.
- STABLE_SAMPLES, 4: consecutive identical candidate samples required to commit a new code. Constraint: >= 1.

Ports:
- clk, input, 1: single clock. All logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- sample_valid, input, 1: qualifies roll_raw and pitch_raw for one cycle.
- roll_raw, input, DATA_W: signed roll sample. Positive means right.
- pitch_raw, input, DATA_W: signed pitch sample. Positive means up.
- orientation, output, 4: committed code, 0–8.
- orient_valid, output, 1: one-cycle pulse per processed sample, aligned with the orientation register update.
- orient_changed, output, 1: one-cycle pulse when orientation takes a new value.

## Operation
- **Axis state machine.** Each axis has states NEUTRAL, POS and NEG. It advances only when sample_valid is high.
  - NEUTRAL: go to POS if raw > ENTER_TH; go to NEG if raw < −ENTER_TH; otherwise stay.
  - POS: go to NEG if raw < −ENTER_TH; else go to NEUTRAL if raw < EXIT_TH; else stay.
  - NEG: mirror of POS.
- **Comparisons.**
  - Compare signed at DATA_W+1 bits, with thresholds sign-extended, so that −ENTER_TH and the most negative raw value cannot overflow.
  - A raw value equal to a threshold does not cross it.
- **Candidate code.** Formed from {roll_dir, pitch_dir}:
  - 0 neutral, 1 up, 2 up-right, 3 right, 4 down-right
  - 5 down, 6 down-left, 7 left, 8 up-left
- **Debounce.** Applied per processed sample, using a count register cnt and a tracked candidate register trk.
  - If candidate == orientation: cnt ← 0.
  - Else if candidate == trk: cnt ← cnt + 1.
  - Else: trk ← candidate and cnt ← 1.
  - When the resulting count reaches STABLE_SAMPLES, commit: orientation ← candidate, pulse orient_changed, cnt ← 0.
- **Idle samples.** Cycles with sample_valid low change no state; cnt is held.
- **Count width.** cnt is $clog2(STABLE_SAMPLES+1) bits. It never exceeds STABLE_SAMPLES.

## Timing
- **Pipeline.** Two stages.
  - Edge 1: sample accepted, axis states update.
  - Edge 2: debounce/commit evaluated, orientation, orient_valid and orient_changed registered.
  - Latency: orientation reflects a sample 2 clocks after the edge that accepted it.
- **Throughput.** sample_valid may be high on every cycle. Back-to-back samples are fully pipelined, with no stall and no backpressure.
- **Strobes.** orient_changed is high only in a cycle where orient_valid is also high.
- **Reset values.** Both axes NEUTRAL, orientation 0, trk 0, cnt 0, orient_valid 0, orient_changed 0.
- **Reset mid-operation.** Samples in flight are discarded and no strobe is emitted for them. A full STABLE_SAMPLES run is needed after reset.
- **STABLE_SAMPLES = 1.** Commit on the first differing sample, still at 2-cycle latency.

## Structure
- **Package orientation_pkg:**
  - direction typedef: DIR_NEUTRAL = 2'b00, DIR_POS = 2'b01, DIR_NEG = 2'b11.
  - orientation code constants ORIENT_NEUTRAL … ORIENT_UP_LEFT (0–8).
  - pure function encode_orientation(roll_dir, pitch_dir), returning 0 for undefined combinations.
- **Sub-module axis_hysteresis.** Parameters DATA_W, ENTER_TH, EXIT_TH. Ports clk, rst, sample_valid, raw, and a registered dir output. Instantiated twice.
- **Top-level.** Holds the valid pipeline, the debounce counter and the commit registers.

## Test plan
Defaults are used unless stated.
- **First commit.** Reset, then 4 consecutive samples roll=500, pitch=0 → orientation goes to 3 with orient_changed, 2 cycles after the 4th sample. orient_valid pulses 4 times and orient_changed once.
- **Hysteresis.** From code 3: 10 samples with roll=350 → stays 3. Then 4 samples with roll=250 → 0. Then samples with roll=400 exactly → stays 0.
- **Glitch rejection.** From 0: 3 samples (500, 500) then 1 sample (0, 0), then 3 more (500, 500) → no commit. A 4th (500, 500) → code 2.
- **Direct reversal and extreme value.** From 3: 4 samples with roll=−500 → 7, never passing through 0. Separately, roll=0, pitch=−32768 for 4 samples → 5.
- **Candidate switch.** From 0: 2 samples of code 2 followed by 4 samples of code 8 → commits 8 on the 4th; 2 is never output.
- **Gaps and reset.**
  - 3 samples of code 1, 20 idle cycles, then 1 more → commits 1.
  - Repeat, but assert rst for 1 cycle after the 3rd sample → all outputs 0 and no strobe; 4 fresh samples are required to commit.
